// File: rtl/mips_cpu_ram_stall.sv
// Avalon-MM word memory for CPU benches: configurable depth/base, fixed plus optional
// LFSR-driven waitrequest stalls, byte lanes, and out-of-range / halt-address decoding.
module mips_cpu_ram_stall #(
  parameter logic [31:0] BASE_ADDR    = 32'hBFC00000,
  parameter int unsigned DEPTH_LOG2   = 12,
  parameter int unsigned LATENCY      = 0,
  parameter bit          RANDOM_STALL = 1'b0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] address_i,
  input  logic        write_i,
  input  logic        read_i,
  output logic        waitrequest_o,
  input  logic [31:0] writedata_i,
  input  logic [3:0]  byteenable_i,
  output logic [31:0] readdata_o,
  output logic        addr_error_o
);

  localparam int unsigned WORDS  = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned WOFF_W = 30;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    S_IDLE,
    S_STALL
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    stall_n;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [31:0]         mem_q [WORDS];

  logic                req;
  logic                is_rd;
  logic                complete;
  logic [WOFF_W-1:0]   word_off;
  logic                in_range;
  logic                is_halt;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]         be_mask;
  logic                mem_we;
  logic                unused_addr_lsb;

  // Address decode: word offset from base, halt match on the word address
  assign word_off        = address_i[31:2] - BASE_ADDR[31:2];
  assign in_range        = (word_off >> DEPTH_LOG2) == '0;
  assign idx             = word_off[DEPTH_LOG2-1:0];
  assign is_halt         = address_i[31:2] == HALT_ADDR[31:2];
  assign unused_addr_lsb = ^address_i[1:0];

  assign req     = write_i | read_i;
  assign is_rd   = read_i & ~write_i;
  assign be_mask = {{8{byteenable_i[3]}}, {8{byteenable_i[2]}},
                    {8{byteenable_i[1]}}, {8{byteenable_i[0]}}};
  assign stall_n = CNT_W'(LATENCY) + (RANDOM_STALL ? CNT_W'(lfsr_q[1:0]) : CNT_W'(0));

  // Handshake FSM and next-state for registered outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    waitrequest_o = 1'b0;
    complete      = 1'b0;
    lfsr_d        = lfsr_q;
    rdata_d       = rdata_q;
    err_d         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (stall_n == '0) begin
            complete = 1'b1;
          end else begin
            waitrequest_o = 1'b1;
            cnt_d         = stall_n - CNT_W'(1);
            state_d       = S_STALL;
          end
        end
      end
      S_STALL: begin
        if (!req) begin
          // Master dropped its request: abandon without any access
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          waitrequest_o = 1'b1;
          cnt_d         = cnt_q - CNT_W'(1);
        end else begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
      err_d  = ~in_range & ~is_halt;
      if (is_rd) begin
        rdata_d = (in_range && !is_halt) ? (mem_q[idx] & be_mask) : 32'h0;
      end
    end
  end

  assign mem_we = complete & write_i & in_range & ~is_halt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is never reset so contents survive a reset pulse
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable_i[b]) begin
          mem_q[idx][8*b +: 8] <= writedata_i[8*b +: 8];
        end
      end
    end
  end

  assign readdata_o   = rdata_q;
  assign addr_error_o = err_q;

endmodule

// File: tb/tb_mips_cpu_ram_stall.sv
// Scoreboard bench for mips_cpu_ram_stall: four instances with different stall settings share
// one driver; a negedge monitor pops expected results whenever a transfer is accepted.
`timescale 1ns/1ps
module tb_mips_cpu_ram_stall;

  localparam int unsigned NI   = 4;
  localparam logic [31:0] BASE = 32'hBFC00000;

  typedef struct {
    int          inst;
    bit          is_rd;
    logic [31:0] data;
    bit          err;
    int          stall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst    [NI];
  logic [31:0] addr   [NI];
  logic        wr     [NI];
  logic        rd     [NI];
  logic [31:0] wdata  [NI];
  logic [3:0]  be     [NI];
  logic        wait_s [NI];
  logic [31:0] rdata  [NI];
  logic        aerr   [NI];

  exp_t        exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  logic [31:0] exp_rd     [NI];
  bit          pend       [NI];
  int          stall_run  [NI];
  int          stall_meas [NI];
  int          hist       [4];

  always #5 clk = ~clk;

  mips_cpu_ram_stall #(.LATENCY(0)) u_lat0 (
    .clk_i(clk), .rst_i(rst[0]), .address_i(addr[0]), .write_i(wr[0]), .read_i(rd[0]),
    .waitrequest_o(wait_s[0]), .writedata_i(wdata[0]), .byteenable_i(be[0]),
    .readdata_o(rdata[0]), .addr_error_o(aerr[0]));

  mips_cpu_ram_stall #(.LATENCY(3)) u_lat3 (
    .clk_i(clk), .rst_i(rst[1]), .address_i(addr[1]), .write_i(wr[1]), .read_i(rd[1]),
    .waitrequest_o(wait_s[1]), .writedata_i(wdata[1]), .byteenable_i(be[1]),
    .readdata_o(rdata[1]), .addr_error_o(aerr[1]));

  mips_cpu_ram_stall #(.LATENCY(4)) u_lat4 (
    .clk_i(clk), .rst_i(rst[2]), .address_i(addr[2]), .write_i(wr[2]), .read_i(rd[2]),
    .waitrequest_o(wait_s[2]), .writedata_i(wdata[2]), .byteenable_i(be[2]),
    .readdata_o(rdata[2]), .addr_error_o(aerr[2]));

  mips_cpu_ram_stall #(.LATENCY(1), .RANDOM_STALL(1'b1)) u_rnd (
    .clk_i(clk), .rst_i(rst[3]), .address_i(addr[3]), .write_i(wr[3]), .read_i(rd[3]),
    .waitrequest_o(wait_s[3]), .writedata_i(wdata[3]), .byteenable_i(be[3]),
    .readdata_o(rdata[3]), .addr_error_o(aerr[3]));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: outcome of a transfer accepted at the previous edge is checked here
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      automatic bit   exp_err;
      automatic exp_t e;
      exp_err = 1'b0;
      if (pend[i]) begin
        pend[i] = 1'b0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_accept inst%0d: got accepted transfer expected none", i);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("stall_len_inst%0d", i), 32'(stall_meas[i]), 32'(e.stall));
          if (i == 3 && stall_meas[i] >= 1 && stall_meas[i] <= 4) hist[stall_meas[i]-1]++;
          if (e.is_rd) exp_rd[i] = e.data;
          exp_err = e.err;
        end
      end
      if (rst[i]) begin
        exp_rd[i]    = 32'h0;
        exp_err      = 1'b0;
        stall_run[i] = 0;
      end
      check($sformatf("readdata_inst%0d", i), rdata[i], exp_rd[i]);
      check($sformatf("addr_error_inst%0d", i), 32'(aerr[i]), 32'(exp_err));
      if (!(wr[i] || rd[i])) begin
        check($sformatf("wait_idle_inst%0d", i), 32'(wait_s[i]), 32'h0);
        stall_run[i] = 0;
      end else if (!rst[i]) begin
        if (wait_s[i]) begin
          stall_run[i]++;
        end else begin
          pend[i]       = 1'b1;
          stall_meas[i] = stall_run[i];
          stall_run[i]  = 0;
        end
      end
    end
  end

  // Issue one transfer (called at posedge+1) and hold it until accepted
  task automatic xfer(input int i, input bit w_en, input bit r_en, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b, input logic [31:0] exp_d,
                      input bit exp_e, input int exp_st);
    exp_t e;
    bit   done;
    e.inst = i; e.is_rd = r_en && !w_en; e.data = exp_d; e.err = exp_e; e.stall = exp_st;
    exp_q.push_back(e);
    addr[i] = a; wdata[i] = d; be[i] = b; wr[i] = w_en; rd[i] = r_en;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (!wait_s[i]) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout inst%0d: got waitrequest stuck high expected accept", i);
      void'(exp_q.pop_back());
    end
    @(posedge clk); #1;
    wr[i] = 1'b0;
    rd[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [31:0] mm [16];
    logic [15:0] lf;
    logic [31:0] d;
    logic [3:0]  b;
    int          w;
    int          st;
    bit          do_wr;

    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; wr[i] = 1'b0; rd[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0; be[i] = '0;
      exp_rd[i] = '0; pend[i] = 1'b0; stall_run[i] = 0; stall_meas[i] = 0;
    end
    for (int j = 0; j < 4; j++) hist[j] = 0;
    idle(3);
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    idle(1);

    // Zero-latency write/read, lanes, unaligned address, write-over-read priority
    xfer(0, 1, 0, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0);
    xfer(0, 0, 1, BASE + 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0, 0);
    xfer(0, 1, 0, BASE + 32'h20, 32'h11223344, 4'hF, 32'h0, 0, 0);
    xfer(0, 1, 0, BASE + 32'h20, 32'h000000AA, 4'b0001, 32'h0, 0, 0);
    idle(2);
    xfer(0, 0, 1, BASE + 32'h20, 32'h0, 4'b0011, 32'h000033AA, 0, 0);
    xfer(0, 0, 1, BASE + 32'h20, 32'h0, 4'hF, 32'h112233AA, 0, 0);
    xfer(0, 0, 1, BASE + 32'h13, 32'h0, 4'hF, 32'hDEADBEEF, 0, 0);
    xfer(0, 1, 1, BASE + 32'h10, 32'h0BADF00D, 4'hF, 32'h0, 0, 0);
    xfer(0, 0, 1, BASE + 32'h10, 32'h0, 4'hF, 32'h0BADF00D, 0, 0);

    // Range edges, aliasing of out-of-range writes, halt address
    xfer(0, 1, 0, BASE, 32'hCAFEF00D, 4'hF, 32'h0, 0, 0);
    xfer(0, 1, 0, BASE + 32'h3FFC, 32'h5A5A5A5A, 4'hF, 32'h0, 0, 0);
    xfer(0, 0, 1, BASE + 32'h3FFC, 32'h0, 4'hF, 32'h5A5A5A5A, 0, 0);
    xfer(0, 0, 1, 32'hBFC10000, 32'h0, 4'hF, 32'h0, 1, 0);
    xfer(0, 0, 1, BASE + 32'h10, 32'h0, 4'hF, 32'h0BADF00D, 0, 0);
    xfer(0, 0, 1, BASE + 32'h4000, 32'h0, 4'hF, 32'h0, 1, 0);
    xfer(0, 0, 1, BASE + 32'h10, 32'h0, 4'hF, 32'h0BADF00D, 0, 0);
    xfer(0, 0, 1, BASE - 32'h4, 32'h0, 4'hF, 32'h0, 1, 0);
    xfer(0, 1, 0, BASE + 32'h4000, 32'h12345678, 4'hF, 32'h0, 1, 0);
    xfer(0, 1, 0, 32'h00000000, 32'hFFFFFFFF, 4'hF, 32'h0, 0, 0);
    idle(2);
    xfer(0, 0, 1, BASE, 32'h0, 4'hF, 32'hCAFEF00D, 0, 0);
    xfer(0, 0, 1, 32'h00000000, 32'h0, 4'hF, 32'h0, 0, 0);

    // Fixed latency 3, including back-to-back reads
    xfer(1, 1, 0, BASE, 32'h13579BDF, 4'hF, 32'h0, 0, 3);
    xfer(1, 1, 0, BASE + 32'h4, 32'h2468ACE0, 4'hF, 32'h0, 0, 3);
    xfer(1, 0, 1, BASE, 32'h0, 4'hF, 32'h13579BDF, 0, 3);
    xfer(1, 0, 1, BASE + 32'h4, 32'h0, 4'hF, 32'h2468ACE0, 0, 3);
    idle(2);

    // Latency 4 with reset arriving mid-stall of a write
    xfer(2, 1, 0, BASE + 32'h8, 32'h600DCAFE, 4'hF, 32'h0, 0, 4);
    xfer(2, 0, 1, BASE + 32'h8, 32'h0, 4'hF, 32'h600DCAFE, 0, 4);
    addr[2] = BASE + 32'h8; wdata[2] = 32'hBAD0BAD0; be[2] = 4'hF; wr[2] = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst[2] = 1'b1;
    wr[2]  = 1'b0;
    idle(2);
    rst[2] = 1'b0;
    idle(1);
    xfer(2, 0, 1, BASE + 32'h8, 32'h0, 4'hF, 32'h600DCAFE, 0, 4);

    // Pseudo-random stalls against a reference Galois LFSR and shadow memory
    lf = 16'hACE1;
    for (int k = 0; k < 1000; k++) begin
      w     = (k < 16) ? k : int'($urandom_range(15, 0));
      do_wr = (k < 16) ? 1'b1 : 1'($urandom_range(1, 0));
      d     = $urandom;
      b     = (k < 16) ? 4'hF : 4'($urandom_range(15, 1));
      st    = 1 + int'(lf[1:0]);
      if (do_wr) begin
        for (int n = 0; n < 4; n++) if (b[n]) mm[w][8*n +: 8] = d[8*n +: 8];
        xfer(3, 1, 0, BASE + 32'(4 * w), d, b, 32'h0, 0, st);
      end else begin
        xfer(3, 0, 1, BASE + 32'(4 * w), 32'h0, 4'hF, mm[w], 0, st);
      end
      lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
    end
    idle(3);

    for (int j = 0; j < 4; j++) begin
      check($sformatf("stall_value_%0d_seen", j + 1), 32'(hist[j] != 0), 32'h1);
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
